timer_bank: RTL and testbench

//  Bank of CHANNELS independent up/down timers sharing one programmable prescaler.

---
 rtl/timer_bank_if.sv | 23 ++
 rtl/timer_bank.sv | 57 +++++
 tb/tb_timer_bank.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// timer_bank_if: control/status bundle between the register file and the timer bank.
interface timer_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int PRESC_W  = 8
);
    logic [PRESC_W-1:0]        prescale;
    logic [CHANNELS-1:0]       enable;
    logic [2*CHANNELS-1:0]     mode;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] reload_value;
    logic [CHANNELS*WIDTH-1:0] counter;
    logic [CHANNELS-1:0]       delay_pending;
    logic [CHANNELS-1:0]       expired;
    modport master (
        output prescale, enable, mode, load, reload_value,
        input  counter, delay_pending, expired
    );
    modport slave (
        input  prescale, enable, mode, load, reload_value,
        output counter, delay_pending, expired
    );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: CHANNELS up/down timers sharing one free-running prescaler.
module timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int PRESC_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    timer_bank_if.slave bus
);
    logic [PRESC_W-1:0] p_q, p_d;
    logic               tick;
    // Compare with >= so lowering prescale below the running count ticks at once
    assign tick = p_q >= bus.prescale;
    assign p_d  = tick ? '0 : p_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) p_q <= '0;
        else     p_q <= p_d;
    end
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d, rv;
        logic [1:0]       m;
        logic             adv, done_q, done_d, seen_q, exp_q, exp_d;
        assign rv     = bus.reload_value[WIDTH*n +: WIDTH];
        assign m      = bus.mode[2*n +: 2];
        assign adv    = tick & bus.enable[n] & ~done_q;
        // Up-once freezes on the first disabled cycle after any enabled one
        assign done_d = done_q | ((m == 2'b01) & seen_q & ~bus.enable[n]);
        always_comb begin
            cnt_d = cnt_q;
            exp_d = 1'b0;
            if (adv && !m[1]) begin
                cnt_d = cnt_q + 1'b1;
                exp_d = &cnt_q;
            end else if (adv && cnt_q != '0) begin
                cnt_d = (m[0] && cnt_q == WIDTH'(1)) ? rv : cnt_q - 1'b1;
                exp_d = cnt_q == WIDTH'(1);
            end
        end
        always_ff @(posedge clk) begin
            if (rst || bus.load[n]) begin
                cnt_q  <= m[1] ? rv : '0;
                done_q <= 1'b0;
                seen_q <= 1'b0;
                exp_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                done_q <= done_d;
                seen_q <= seen_q | bus.enable[n];
                exp_q  <= exp_d;
            end
        end
        assign bus.counter[WIDTH*n +: WIDTH] = cnt_q;
        assign bus.expired[n]                = exp_q;
        assign bus.delay_pending[n]          = m[1] & (cnt_q != '0);
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of the 4x32 bank and a 1x8 instance for wrap behaviour.
module tb_timer_bank;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    always #5 clk = ~clk;

    timer_bank_if #(.CHANNELS(4), .WIDTH(32), .PRESC_W(8)) bus ();
    timer_bank_if #(.CHANNELS(1), .WIDTH(8),  .PRESC_W(8)) bus8 ();
    timer_bank #(.CHANNELS(4), .WIDTH(32), .PRESC_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    timer_bank #(.CHANNELS(1), .WIDTH(8),  .PRESC_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    function automatic logic [31:0] cnt(input int n);
        return bus.counter[32*n +: 32];
    endfunction

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.prescale = 0; bus.enable = 0; bus.mode = 0; bus.load = 0; bus.reload_value = 0;
        bus8.prescale = 0; bus8.enable = 0; bus8.mode = 0; bus8.load = 0; bus8.reload_value = 0;
        do_reset;
        checks++;
        if (bus.counter !== 128'd0) begin fails++; $display("FAIL reset_counter: got %h expected 0", bus.counter); end
        checks++;
        if (bus.expired !== 4'd0 || bus.delay_pending !== 4'd0) begin
            fails++; $display("FAIL reset_flags: got exp=%b pend=%b expected 0000/0000", bus.expired, bus.delay_pending);
        end
        checks++;
        if (bus8.counter !== 8'd0) begin fails++; $display("FAIL reset_counter8: got %0d expected 0", bus8.counter); end
    endtask

    task automatic test_up;
        bus.enable[0] = 1'b1; cycles(10);
        checks++;
        if (cnt(0) !== 32'd10) begin fails++; $display("FAIL up_run1: got %0d expected 10", cnt(0)); end
        bus.enable[0] = 1'b0; cycles(10);
        checks++;
        if (cnt(0) !== 32'd10) begin fails++; $display("FAIL up_hold: got %0d expected 10", cnt(0)); end
        bus.enable[0] = 1'b1; cycles(10);
        checks++;
        if (cnt(0) !== 32'd20) begin fails++; $display("FAIL up_run2: got %0d expected 20", cnt(0)); end
        bus.enable[0] = 1'b0;
        do_reset;
        checks++;
        if (cnt(0) !== 32'd0 || bus.delay_pending[0] !== 1'b0) begin
            fails++; $display("FAIL up_rst: got %0d pend %b expected 0 pend 0", cnt(0), bus.delay_pending[0]);
        end
    endtask

    task automatic test_up_once;
        bus.mode[3:2] = 2'b01;
        do_reset;
        bus.enable[1] = 1'b1; cycles(10);
        checks++;
        if (cnt(1) !== 32'd10) begin fails++; $display("FAIL once_run: got %0d expected 10", cnt(1)); end
        bus.enable[1] = 1'b0; cycles(10);
        bus.enable[1] = 1'b1; cycles(10);
        checks++;
        if (cnt(1) !== 32'd10) begin fails++; $display("FAIL once_done: got %0d expected 10", cnt(1)); end
        bus.enable[1] = 1'b0; bus.load[1] = 1'b1; cycles(1);
        bus.load[1] = 1'b0;
        checks++;
        if (cnt(1) !== 32'd0) begin fails++; $display("FAIL once_load: got %0d expected 0", cnt(1)); end
        bus.enable[1] = 1'b1; cycles(5);
        checks++;
        if (cnt(1) !== 32'd5) begin fails++; $display("FAIL once_rerun: got %0d expected 5", cnt(1)); end
        bus.enable[1] = 1'b0;
    endtask

    task automatic test_oneshot;
        int pulses = 0;
        bus.mode[5:4] = 2'b10; bus.reload_value[64 +: 32] = 32'd50;
        do_reset;
        checks++;
        if (cnt(2) !== 32'd50 || bus.delay_pending[2] !== 1'b1) begin
            fails++; $display("FAIL shot_init: got %0d pend %b expected 50 pend 1", cnt(2), bus.delay_pending[2]);
        end
        bus.enable[2] = 1'b1; cycles(10);
        checks++;
        if (cnt(2) !== 32'd40) begin fails++; $display("FAIL shot_40: got %0d expected 40", cnt(2)); end
        for (int i = 1; i <= 40; i++) begin
            cycles(1);
            if (bus.expired[2]) pulses++;
        end
        checks++;
        if (cnt(2) !== 32'd0 || bus.delay_pending[2] !== 1'b0 || pulses != 1) begin
            fails++; $display("FAIL shot_zero: got %0d pend %b pulses %0d expected 0 pend 0 pulses 1", cnt(2), bus.delay_pending[2], pulses);
        end
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cycles(1);
            if (bus.expired[2]) pulses++;
        end
        checks++;
        if (cnt(2) !== 32'd0 || pulses != 0) begin
            fails++; $display("FAIL shot_hold: got %0d pulses %0d expected 0 pulses 0", cnt(2), pulses);
        end
        bus.enable[2] = 1'b0;
    endtask

    task automatic test_periodic;
        logic [31:0] e_cnt;
        bus.mode[7:6] = 2'b11; bus.reload_value[96 +: 32] = 32'd5; bus.prescale = 8'd3;
        do_reset;
        bus.enable[3] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cycles(1);
            e_cnt = 32'(5 - ((i / 4) % 5));
            checks++;
            if (cnt(3) !== e_cnt || bus.expired[3] !== (i % 20 == 0) || bus.delay_pending[3] !== 1'b1) begin
                fails++;
                $display("FAIL periodic_step%0d: got %0d exp %b pend %b expected %0d exp %b pend 1",
                         i, cnt(3), bus.expired[3], bus.delay_pending[3], e_cnt, (i % 20 == 0));
            end
        end
        bus.enable[3] = 1'b0; bus.prescale = 8'd0;
    endtask

    task automatic test_width8;
        int pulses = 0;
        bus8.mode = 2'b00; bus8.enable = 1'b1; bus8.load = 1'b1; cycles(1);
        bus8.load = 1'b0;
        checks++;
        if (bus8.counter !== 8'd0) begin fails++; $display("FAIL w8_load: got %0d expected 0", bus8.counter); end
        for (int i = 1; i <= 256; i++) begin
            cycles(1);
            if (bus8.expired[0]) pulses++;
            if (i == 255) begin
                checks++;
                if (bus8.counter !== 8'd255) begin fails++; $display("FAIL w8_255: got %0d expected 255", bus8.counter); end
            end
        end
        checks++;
        if (bus8.counter !== 8'd0 || pulses != 1) begin
            fails++; $display("FAIL w8_wrap: got %0d pulses %0d expected 0 pulses 1", bus8.counter, pulses);
        end
        pulses = 0;
        bus8.mode = 2'b11; bus8.reload_value = 8'd0; bus8.load = 1'b1; cycles(1);
        bus8.load = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cycles(1);
            if (bus8.expired[0]) pulses++;
        end
        checks++;
        if (bus8.counter !== 8'd0 || pulses != 0 || bus8.delay_pending[0] !== 1'b0) begin
            fails++; $display("FAIL w8_reload0: got %0d pulses %0d pend %b expected 0 pulses 0 pend 0", bus8.counter, pulses, bus8.delay_pending[0]);
        end
        bus8.enable = 1'b0;
    endtask

    task automatic test_back_to_back;
        bus.mode[5:4] = 2'b10; bus.reload_value[64 +: 32] = 32'd50; bus.prescale = 8'd0;
        do_reset;
        bus.enable[2] = 1'b1; cycles(5);
        checks++;
        if (cnt(2) !== 32'd45) begin fails++; $display("FAIL b2b_45: got %0d expected 45", cnt(2)); end
        bus.load[2] = 1'b1; cycles(1);
        bus.load[2] = 1'b0;
        checks++;
        if (cnt(2) !== 32'd50) begin fails++; $display("FAIL b2b_load_wins: got %0d expected 50", cnt(2)); end
        bus.reload_value[64 +: 32] = 32'd30; cycles(6);
        checks++;
        if (cnt(2) !== 32'd44) begin fails++; $display("FAIL b2b_reload_late: got %0d expected 44", cnt(2)); end
        bus.prescale = 8'd3;
        do_reset;
        checks++;
        if (cnt(2) !== 32'd30) begin fails++; $display("FAIL b2b_rst_value: got %0d expected 30", cnt(2)); end
        cycles(3);
        checks++;
        if (cnt(2) !== 32'd30) begin fails++; $display("FAIL b2b_presc_hold: got %0d expected 30", cnt(2)); end
        cycles(1);
        checks++;
        if (cnt(2) !== 32'd29) begin fails++; $display("FAIL b2b_presc_tick: got %0d expected 29", cnt(2)); end
        bus.enable[2] = 1'b0;
    endtask

    initial begin
        test_reset;
        test_up;
        test_up_once;
        test_oneshot;
        test_periodic;
        test_width8;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
